// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module : mod_counter_pkg
// Brief  : Shared types, defaults and load-clamp helper for mod_counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

  typedef enum logic [0:0] {
    SNAP_IDLE  = 1'b0,
    SNAP_SHIFT = 1'b1
  } snap_state_t;

  localparam int C_DEFAULT_WIDTH = 8;

  // Out-of-range load values collapse onto the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_counter_snap_shifter.sv
// ============================================================================
// Module : snap_shifter
// Brief  : Parallel-in serial-out snapshot shifter, MSB first, with
//          IDLE/SHIFT control; requests while shifting are dropped.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module snap_shifter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_sd,
  output logic             o_sd_valid,
  output logic             o_busy
);

  localparam int                 C_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  snap_state_t        r_state;
  snap_state_t        w_state_next;
  logic [WIDTH-1:0]   r_shreg;
  logic [C_CNT_W-1:0] r_bit_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= SNAP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SNAP_IDLE:  if (i_start) w_state_next = SNAP_SHIFT;
      SNAP_SHIFT: if (r_bit_cnt == '0) w_state_next = SNAP_IDLE;
      default:    w_state_next = SNAP_IDLE;
    endcase
  end

  // The bit counter holds the index of the bit currently on o_sd.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if ((r_state == SNAP_IDLE) && i_start) begin
      r_shreg   <= i_data;
      r_bit_cnt <= C_LAST_BIT;
    end else if (r_state == SNAP_SHIFT) begin
      r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
      r_bit_cnt <= (r_bit_cnt == '0) ? '0 : (r_bit_cnt - C_CNT_ONE);
    end
  end

  always_comb begin
    o_sd_valid = (r_state == SNAP_SHIFT);
    o_busy     = (r_state == SNAP_SHIFT);
    o_sd       = (r_state == SNAP_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module : mod_counter
// Brief  : Up/down modulo counter with preset, clamped load, terminal count
//          and serial snapshot readout.
//          MOD_COUNTER_SATURATE_EN: saturate at the range ends instead of wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH      = C_DEFAULT_WIDTH,
  parameter int MODULUS    = 2**WIDTH,
  parameter int PRESET_VAL = MODULUS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             snap_req,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sd,
  output logic             sd_valid,
  output logic             busy
);

  localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_PRESET  = WIDTH'(PRESET_VAL);
  localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   C_ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_next;

  // One extra bit lets the modulus compare and the borrow out of zero be seen
  // directly, so a short modulus never wraps through 2**WIDTH.
  always_comb begin
    w_inc = {1'b0, r_count} + C_ONE_EXT;
    w_dec = {1'b0, r_count} - C_ONE_EXT;
    if (up) begin
`ifdef MOD_COUNTER_SATURATE_EN
      w_step = (w_inc == C_MOD_EXT) ? r_count : w_inc[WIDTH-1:0];
`else
      w_step = (w_inc == C_MOD_EXT) ? '0 : w_inc[WIDTH-1:0];
`endif
    end else begin
`ifdef MOD_COUNTER_SATURATE_EN
      w_step = w_dec[WIDTH] ? r_count : w_dec[WIDTH-1:0];
`else
      w_step = w_dec[WIDTH] ? C_MAX : w_dec[WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    w_load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS - 1)));
    if (preset) begin
      w_count_next = C_PRESET;
    end else if (load) begin
      w_count_next = w_load_clamped;
    end else if (en) begin
      w_count_next = w_step;
    end else begin
      w_count_next = r_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;
  assign tc    = up ? (r_count == C_MAX) : (r_count == '0);

  // Snapshot sees the pre-update count present at the requesting edge.
  snap_shifter #(
    .WIDTH (WIDTH)
  ) u_snap_shifter (
    .clk        (clk),
    .reset      (reset),
    .i_start    (snap_req),
    .i_data     (r_count),
    .o_sd       (sd),
    .o_sd_valid (sd_valid),
    .o_busy     (busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module : tb_mod_counter
// Brief  : Self-checking bench for mod_counter (WIDTH=4, MODULUS=10) against
//          a behavioural model; honours MOD_COUNTER_SATURATE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
  localparam int PRE = 9;
`ifdef MOD_COUNTER_SATURATE_EN
  localparam int C_DOWN1 = 0;
  localparam int C_DOWN2 = 0;
`else
  localparam int C_DOWN1 = 9;
  localparam int C_DOWN2 = 8;
`endif

  logic         clk = 1'b0;
  logic         reset, en, up, preset, load, snap_req;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, sd, sd_valid, busy;

  int checks   = 0;
  int failures = 0;

  int m_count  = 0;
  bit m_valid  = 1'b0;
  bit m_bits[$];
  bit m_junk;

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH      (W),
    .MODULUS    (MOD),
    .PRESET_VAL (PRE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .preset   (preset),
    .load     (load),
    .load_val (load_val),
    .snap_req (snap_req),
    .count    (count),
    .tc       (tc),
    .sd       (sd),
    .sd_valid (sd_valid),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_next(input int c);
    int n;
    if (preset)                   n = PRE;
    else if (load)                n = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
    else if (!en)                 n = c;
`ifdef MOD_COUNTER_SATURATE_EN
    else if (up)                  n = (c == MOD - 1) ? c : c + 1;
    else                          n = (c == 0) ? 0 : c - 1;
`else
    else if (up)                  n = (c + 1) % MOD;
    else                          n = (c + MOD - 1) % MOD;
`endif
    return n;
  endfunction

  // Reference model: a queue holds the snapshot bits still to appear on sd.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_count = 0;
        m_bits.delete();
        m_valid = 1'b1;
      end else begin
        if (m_bits.size() > 0) begin
          m_junk = m_bits.pop_front();
        end else if (snap_req) begin
          for (int b = W - 1; b >= 0; b--) m_bits.push_back(bit'((m_count >> b) & 1));
        end
        m_count = model_next(m_count);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("count",    count,    m_count);
        chk("tc",       tc,       up ? (m_count == MOD - 1) : (m_count == 0));
        chk("sd_valid", sd_valid, m_bits.size() > 0);
        chk("busy",     busy,     m_bits.size() > 0);
        chk("sd",       sd,       (m_bits.size() > 0) ? m_bits[0] : 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; en = 0; up = 0; preset = 0; load = 0; load_val = '0; snap_req = 0;
    repeat (3) tick();
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sd_valid", sd_valid, 0);

    reset = 1; en = 1; up = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("up_count", count, i % 10);
      chk("up_tc", tc, (i % 10) == 9);
    end

    en = 0; up = 0; load = 1; load_val = 4'd0;
    tick();
    chk("down_start_count", count, 0);
    chk("down_start_tc", tc, 1);
    load = 0; en = 1;
    tick();
    chk("down_first", count, C_DOWN1);
    tick();
    chk("down_second", count, C_DOWN2);

    preset = 1; load = 1; load_val = 4'd3;
    tick();
    chk("preset_over_load", count, 9);
    preset = 0; load_val = 4'd14;
    tick();
    chk("load_clamp", count, 9);
    load_val = 4'd5;
    tick();
    chk("load_5", count, 5);

    load_val = 4'd6;
    tick();
    load = 0; en = 0; snap_req = 1;
    tick();
    chk("snap_bit3", sd, 0);
    chk("snap_valid", sd_valid, 1);
    chk("snap_busy", busy, 1);
    tick();
    chk("snap_bit2", sd, 1);
    tick();
    chk("snap_bit1", sd, 1);
    tick();
    chk("snap_bit0", sd, 0);
    chk("snap_bit0_valid", sd_valid, 1);
    tick();
    chk("snap_req_in_shift_ignored", busy, 0);
    chk("snap_end_valid", sd_valid, 0);
    snap_req = 0;

    en = 1; up = 1; snap_req = 1;
    tick();
    snap_req = 0;
    tick();
    chk("mid_bit2", sd, 1);
    reset = 0;
    tick();
    chk("midrst_count", count, 0);
    chk("midrst_sd", sd, 0);
    chk("midrst_valid", sd_valid, 0);
    chk("midrst_busy", busy, 0);
    reset = 1; en = 0; snap_req = 1;
    tick();
    chk("snap_after_reset", busy, 1);
    snap_req = 0;

    load = 1; load_val = 4'd9;
    tick();
    load = 0; en = 0;
    for (int i = 0; i < 6; i++) begin
      up = i[0];
      tick();
      chk("hold_count", count, 9);
      chk("hold_tc", tc, i[0]);
    end

    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 31) != 0);
      preset   = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) == 1;
      snap_req = ($urandom_range(0, 5) == 0);
      tick();
    end

    reset = 1; preset = 0; load = 0; en = 0; snap_req = 0;
    repeat (W + 2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
